// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-PC select codes,
// sequencer state encoding and default geometry.
package pc_pkg;

   localparam int DEFAULT_AW        = 5;
   localparam int DEFAULT_RAS_DEPTH = 4;

   localparam logic [2:0] SEL_SEQ  = 3'd0;
   localparam logic [2:0] SEL_SKIP = 3'd1;
   localparam logic [2:0] SEL_JUMP = 3'd2;
   localparam logic [2:0] SEL_CALL = 3'd3;
   localparam logic [2:0] SEL_RET  = 3'd4;
   localparam logic [2:0] SEL_HOLD = 3'd5;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle: flow-control requests in, fetch address
// and status out.
interface pc_sequencer_if
   import pc_pkg::*;
#(
   parameter int AW        = DEFAULT_AW,
   parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
);
   localparam int CW = $clog2(RAS_DEPTH) + 1;

   // No valid/ready handshake: every request is a level sampled on each rising
   // edge and is either acted on or dropped by priority; there is no backpressure.
   logic          stall;
   logic          halt;
   logic          skip;
   logic          jump;
   logic          call;
   logic          ret;
   logic [AW-1:0] jump_addr;

   logic [AW-1:0] pc;
   logic          halted;
   logic [CW-1:0] ras_count;
   logic          ras_overflow;
   logic          ras_underflow;
   logic [0:0]    state;

   modport master (
      output stall, halt, skip, jump, call, ret, jump_addr,
      input  pc, halted, ras_count, ras_overflow, ras_underflow, state
   );

   modport slave (
      input  stall, halt, skip, jump, call, ret, jump_addr,
      output pc, halted, ras_count, ras_overflow, ras_underflow, state
   );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO. Full push and empty pop are ignored here; the caller
// turns them into sticky error flags.
module ras_stack #(
   parameter int W     = 5,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  top,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] top_idx;

   // DEPTH is a power of two, so the low bits of the count wrap cleanly.
   assign wr_idx  = cnt_q[PW-1:0];
   assign top_idx = wr_idx - PW'(1);
   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign top     = mem[top_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (push && !full) begin
         cnt_q <= cnt_q + CW'(1);
      end else if (pop && !empty) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: priority-decodes flow-control requests into a next-PC
// select, keeps the RUN/HALTED state and the sticky stack error flags.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int            AW         = DEFAULT_AW,
   parameter int            RAS_DEPTH  = DEFAULT_RAS_DEPTH,
   parameter logic [AW-1:0] RESET_ADDR = '0
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   localparam int CW = $clog2(RAS_DEPTH) + 1;

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;
   logic [AW-1:0] pc_plus1;
   logic [AW-1:0] pc_plus2;
   logic [AW-1:0] ras_top;
   logic [0:0]    state_q;
   logic [0:0]    state_d;
   logic [2:0]    sel;
   logic          ovf_q;
   logic          unf_q;
   logic          ras_full;
   logic          ras_empty;
   logic          push;
   logic          pop;
   logic [CW-1:0] ras_count;

   assign pc_plus1 = pc_q + AW'(1);
   assign pc_plus2 = pc_q + AW'(2);

   // Halt only takes effect when not stalled; the halting edge itself holds pc.
   always_comb begin
      sel     = SEL_SEQ;
      state_d = state_q;
      if (state_q == ST_HALTED || bus.stall) begin
         sel = SEL_HOLD;
      end else if (bus.halt) begin
         sel     = SEL_HOLD;
         state_d = ST_HALTED;
      end else if (bus.ret) begin
         sel = SEL_RET;
      end else if (bus.call) begin
         sel = SEL_CALL;
      end else if (bus.jump) begin
         sel = SEL_JUMP;
      end else if (bus.skip) begin
         sel = SEL_SKIP;
      end
   end

   always_comb begin
      pc_d = pc_q;
      case (sel)
         SEL_SEQ:  pc_d = pc_plus1;
         SEL_SKIP: pc_d = pc_plus2;
         SEL_JUMP: pc_d = bus.jump_addr;
         SEL_CALL: pc_d = ras_full  ? pc_plus1 : bus.jump_addr;
         SEL_RET:  pc_d = ras_empty ? pc_plus1 : ras_top;
         default:  pc_d = pc_q;
      endcase
   end

   assign push = (sel == SEL_CALL) && !ras_full;
   assign pop  = (sel == SEL_RET)  && !ras_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_ADDR;
         state_q <= ST_RUN;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         ovf_q   <= ovf_q | ((sel == SEL_CALL) && ras_full);
         unf_q   <= unf_q | ((sel == SEL_RET) && ras_empty);
      end
   end

   ras_stack #(
      .W     (AW),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (pc_plus1),
      .top   (ras_top),
      .full  (ras_full),
      .empty (ras_empty),
      .count (ras_count)
   );

   assign bus.pc            = pc_q;
   assign bus.halted        = (state_q == ST_HALTED);
   assign bus.ras_count     = ras_count;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = unf_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based reference model checked
// every cycle, plus literal expectations at the notable points.
module tb_pc_sequencer;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int MOD   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_sequencer_if #(.AW(AW), .RAS_DEPTH(DEPTH)) bus ();

   pc_sequencer #(
      .AW         (AW),
      .RAS_DEPTH  (DEPTH),
      .RESET_ADDR (5'd0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   int m_pc;
   int m_stack[$];
   bit m_halted;
   bit m_ovf;
   bit m_unf;
   bit model_live = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_stack.delete();
      m_halted = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit h, input bit sk, input bit j,
                             input bit c, input bit r, input int a);
      if (m_halted || st) return;
      if (h) m_halted = 1'b1;
      else if (r) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin m_pc = (m_pc + 1) % MOD; m_unf = 1'b1; end
      end else if (c) begin
         if (m_stack.size() < DEPTH) begin
            m_stack.push_back((m_pc + 1) % MOD);
            m_pc = a;
         end else begin
            m_pc = (m_pc + 1) % MOD;
            m_ovf = 1'b1;
         end
      end else if (j) m_pc = a;
      else if (sk) m_pc = (m_pc + 2) % MOD;
      else m_pc = (m_pc + 1) % MOD;
   endtask

   task automatic step(input bit st, input bit h, input bit sk, input bit j,
                       input bit c, input bit r, input int a);
      bus.stall = st; bus.halt = h; bus.skip = sk;
      bus.jump = j; bus.call = c; bus.ret = r;
      bus.jump_addr = AW'(a);
      @(posedge clk);
      model_step(st, h, sk, j, c, r, a);
      #1;
   endtask

   task automatic idle();            step(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_jump(input int a); step(0, 0, 0, 1, 0, 0, a); endtask
   task automatic do_call(input int a); step(0, 0, 0, 0, 1, 0, a); endtask
   task automatic do_ret();          step(0, 0, 0, 0, 0, 1, 0); endtask
   task automatic do_skip();         step(0, 0, 1, 0, 0, 0, 0); endtask

   always @(negedge clk) begin
      if (model_live && !rst) begin
         check("model_pc", bus.pc, m_pc);
         check("model_halted", bus.halted, int'(m_halted));
         check("model_ras_count", bus.ras_count, m_stack.size());
         check("model_ovf", bus.ras_overflow, int'(m_ovf));
         check("model_unf", bus.ras_underflow, int'(m_unf));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bus.stall = 0; bus.halt = 0; bus.skip = 0; bus.jump = 0;
      bus.call = 0; bus.ret = 0; bus.jump_addr = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_pc", bus.pc, 0);
      check("reset_halted", bus.halted, 0);
      check("reset_count", bus.ras_count, 0);
      check("reset_ovf", bus.ras_overflow, 0);
      check("reset_unf", bus.ras_underflow, 0);
      rst = 1'b0;
      model_live = 1'b1;

      // Sequential run through the wrap point
      for (int i = 1; i <= 33; i++) begin
         idle();
         check("seq_pc", bus.pc, i % MOD);
      end
      do_jump(30); do_skip(); check("skip_wrap_30", bus.pc, 0);
      do_jump(31); do_skip(); check("skip_wrap_31", bus.pc, 1);

      // Nested call/return
      do_jump(3);
      do_call(10); check("call1_pc", bus.pc, 10); check("call1_cnt", bus.ras_count, 1);
      idle();      check("call1_next", bus.pc, 11);
      do_call(20); check("call2_pc", bus.pc, 20); check("call2_cnt", bus.ras_count, 2);
      do_ret();    check("ret1_pc", bus.pc, 12);
      do_ret();    check("ret2_pc", bus.pc, 4); check("ret2_cnt", bus.ras_count, 0);

      // Overflow then underflow
      for (int i = 0; i < 4; i++) do_call(8);
      check("fill_cnt", bus.ras_count, 4);
      do_call(8);
      check("ovf_pc", bus.pc, 9); check("ovf_flag", bus.ras_overflow, 1);
      check("ovf_cnt", bus.ras_count, 4);
      for (int i = 0; i < 4; i++) do_ret();
      check("drain_pc", bus.pc, 5); check("drain_cnt", bus.ras_count, 0);
      do_ret();
      check("unf_pc", bus.pc, 6); check("unf_flag", bus.ras_underflow, 1);

      // Stall and priority
      do_jump(5);
      step(1, 0, 0, 1, 0, 0, 17); check("stall_hold", bus.pc, 5);
      do_jump(17);                 check("stall_release", bus.pc, 17);
      do_jump(5);
      do_call(25);                 check("prio_setup", bus.ras_count, 1);
      step(0, 0, 0, 0, 1, 1, 12);  check("call_ret_pc", bus.pc, 6);
      check("call_ret_cnt", bus.ras_count, 0);
      step(0, 0, 1, 1, 0, 0, 22);  check("jump_skip_pc", bus.pc, 22);

      // Asynchronous reset between edges
      do_call(1); do_call(2); do_call(14);
      check("pre_rst_pc", bus.pc, 14); check("pre_rst_cnt", bus.ras_count, 3);
      #1;
      rst = 1'b1;
      model_live = 1'b0;
      #1;
      check("async_pc", bus.pc, 0);
      check("async_cnt", bus.ras_count, 0);
      check("async_ovf", bus.ras_overflow, 0);
      check("async_unf", bus.ras_underflow, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_live = 1'b1;

      // Halt
      step(1, 1, 0, 0, 0, 0, 0);
      check("halt_stall_halted", bus.halted, 0); check("halt_stall_pc", bus.pc, 0);
      do_jump(9);
      step(0, 1, 0, 0, 0, 0, 0);
      check("halt_flag", bus.halted, 1); check("halt_pc", bus.pc, 9);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, i % 2, 1, (i % 3) == 0, 0, 3 + i);
         check("halted_pc", bus.pc, 9);
         check("halted_flag", bus.halted, 1);
      end
      check("halted_cnt", bus.ras_count, 0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit for the 8-bit RISC core; successor to the fixed 5-bit PC and its +1/+2 adders and skip mux.
- Each cycle it selects the next fetch address from sequential, skip, jump, call or return, under stall and halt control.
- Holds an internal return-address stack (RAS) for subroutine call and return.
- Drives the instruction-memory address and status flags to the control unit.

Parameters:
- AW, 5, address width in bits.
- RAS_DEPTH, 4, number of return-address stack entries (>=2, power of 2).
- RESET_ADDR, 0, PC value loaded on reset (AW bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC and stack this cycle.
- halt  in  1  enter halted state; PC frozen until rst.
- skip  in  1  next PC = PC+2 (skip data/next word).
- jump  in  1  next PC = jump_addr.
- call  in  1  push PC+1, next PC = jump_addr.
- ret  in  1  pop; next PC = popped address.
- jump_addr  in  AW  jump/call target.
- pc  out  AW  current fetch address.
- halted  out  1  halted-state indicator.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- ras_overflow  out  1  sticky: call attempted with stack full.
- ras_underflow  out  1  sticky: ret attempted with stack empty.

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_ADDR, halted=0, ras_count=0, both sticky flags=0; stack contents don't-care.
- States: RUN, HALTED.
  - RUN->HALTED on a clock edge with halt=1 and stall=0; PC is not updated on that edge.
  - HALTED->RUN only via rst.
  - In HALTED, all inputs are ignored and outputs hold. pc is always driven; no high-Z.
- Priority in RUN, evaluated per rising edge: stall > halt > ret > call > jump > skip > sequential.
  - stall=1: pc, stack and flags hold; halt is ignored that cycle.
  - ret: if ras_count>0, pc<=top entry and ras_count-1. If empty: pc<=pc+1, ras_underflow<=1, count stays 0.
  - call: if ras_count<RAS_DEPTH, push (pc+1) mod 2^AW, pc<=jump_addr, ras_count+1. If full: no push, pc<=pc+1, ras_overflow<=1.
  - jump: pc<=jump_addr.
  - skip: pc<=(pc+2) mod 2^AW.
  - Otherwise: pc<=(pc+1) mod 2^AW.
- Simultaneous inputs resolve by priority only; lower-priority requests are dropped, not queued.
  - Example: call+ret gives ret only.
  - Example: jump+skip gives jump.
- Arithmetic is unsigned AW-bit with silent wrap: pc=2^AW-1 -> +1 gives 0; pc=2^AW-2 -> +2 gives 0; pc=2^AW-1 -> +2 gives 1.
- Latency: a control input sampled at edge N sets pc after edge N (visible in cycle N+1). No combinational path from inputs to pc.
- Sticky flags clear only on rst.
- Reset mid-call or mid-return discards the stack (count=0).

Decomposition:
- Shared package pc_pkg holds:
  - next-PC select encoding constants (SEL_SEQ, SEL_SKIP, SEL_JUMP, SEL_CALL, SEL_RET, SEL_HOLD);
  - state constants ST_RUN, ST_HALTED;
  - default AW and RAS_DEPTH.
- One sub-module, ras_stack: a LIFO parametrised by width and depth with push/pop/full/empty/count. Push and pop are mutually exclusive by construction.
- pc_sequencer contains the priority decoder, next-PC mux, state register and sticky flags.

Test Plan (AW=5, RAS_DEPTH=4, RESET_ADDR=0):
- Sequential and wrap: release rst, run 33 idle cycles -> pc 0,1,...,31,0,1; from pc=30, skip -> pc=0; from pc=31, skip -> pc=1.
- Call/return nesting, from pc=3:
  - call with jump_addr=10 -> pc=10, ras_count=1;
  - at pc=11, call with jump_addr=20 -> pc=20, count=2;
  - ret -> pc=12; ret -> pc=4, count=0.
- Overflow/underflow:
  - 4 calls with jump_addr=8 -> count=4; 5th call at pc=8 -> pc=9, ras_overflow=1, count=4;
  - after 4 rets, a 5th ret at pc=p -> pc=p+1, ras_underflow=1.
- Stall and priority:
  - stall=1 with jump=1 and jump_addr=17 at pc=5 -> pc stays 5; release -> pc=17;
  - call+ret with count=1 and top=6 -> pc=6, count=0;
  - jump+skip -> pc=jump_addr.
- Halt: halt=1 at pc=9 -> halted=1, pc=9 held for 10 cycles regardless of jump/call; halt+stall together -> not halted.
- Async reset mid-operation: assert rst between edges with count=3 and pc=14 -> pc=0, count=0 and flags=0 immediately, before the next edge.
